ram_port_arbiter: RTL and testbench

- Parametrised successor to the CPU's single-port memory controller.
- Arbitrates NCH requestor channels onto the one byte-wide synchronous RAM port. Typical channels: data load/store, instruction fetch, prefetch.
- Serialises 1-4 byte reads and writes into per-byte RAM cycles and reassembles read words little-endian.
- Adds selectable arbitration, per-channel read abort (flush) and length clamping.

---
 rtl/ram_port_arbiter_pkg.sv | 24 ++
 rtl/ram_port_arbiter_rr_arbiter.sv | 53 +++++
 rtl/ram_port_arbiter.sv | 176 +++++++++++++++++
 tb/tb_ram_port_arbiter.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_port_arbiter_pkg.sv
// Shared types and helpers for the multi-channel byte-serial RAM port arbiter.
package ram_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2
  } state_t;

  localparam int unsigned LEN_MAX = 4;
  localparam int unsigned BYTE_W  = 8;

  // Map a raw 3-bit byte count onto the legal 1..LEN_MAX range.
  function automatic logic [2:0] clamp_len(input logic [2:0] len);
    if (len == 3'd0) begin
      return 3'd1;
    end else if (len > 3'(LEN_MAX)) begin
      return 3'(LEN_MAX);
    end else begin
      return len;
    end
  endfunction

endpackage

// File: rtl/ram_port_arbiter_rr_arbiter.sv
// Request arbiter: fixed lowest-index priority or round-robin from last grant + 1.
module rr_arbiter #(
  parameter int NCH    = 2,
  parameter int ARB_RR = 0,
  parameter int IW     = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           en,
  input  logic [NCH-1:0] req,
  output logic [NCH-1:0] gnt,
  output logic [IW-1:0]  gnt_idx,
  output logic           gnt_any
);

  localparam int unsigned N = NCH;

  logic [IW-1:0] ptr;

  // Pick the first requesting channel along the search order.
  always_comb begin
    int unsigned   cand;
    logic [IW-1:0] cand_idx;
    gnt      = '0;
    gnt_idx  = '0;
    gnt_any  = 1'b0;
    cand     = 0;
    cand_idx = '0;
    for (int unsigned k = 0; k < N; k++) begin
      if (ARB_RR != 0) begin
        cand = (32'(ptr) + 32'd1 + k) % N;
      end else begin
        cand = k;
      end
      cand_idx = IW'(cand);
      if (!gnt_any && req[cand_idx]) begin
        gnt_any       = 1'b1;
        gnt_idx       = cand_idx;
        gnt[cand_idx] = 1'b1;
      end
    end
  end

  // Remember the last granted channel; only moves when a grant is taken.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (en) begin
      ptr <= gnt_idx;
    end
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// Arbitrates NCH requestors onto one byte-wide synchronous RAM port, serialising
// 1-4 byte transfers and reassembling reads little-endian.
module ram_port_arbiter
  import ram_port_arbiter_pkg::*;
#(
  parameter int             NCH        = 2,
  parameter int             AW         = 32,
  parameter int             ARB_RR     = 0,
  parameter logic [NCH-1:0] FLUSH_MASK = 2'b10
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rdy,
  input  logic [NCH-1:0]      req_valid,
  input  logic [NCH-1:0]      req_we,
  input  logic [NCH*AW-1:0]   req_addr,
  input  logic [NCH*32-1:0]   req_wdata,
  input  logic [NCH*3-1:0]    req_len,
  input  logic                flush,
  output logic [NCH-1:0]      done,
  output logic [31:0]         rd_data,
  output logic                busy,
  output logic [AW-1:0]       mem_a,
  output logic                mem_wr,
  output logic [BYTE_W-1:0]   mem_dout,
  input  logic [BYTE_W-1:0]   mem_din
);

  localparam int IW = (NCH > 1) ? $clog2(NCH) : 1;

  state_t         state, state_n;
  logic [NCH-1:0] gnt_oh;
  logic [AW-1:0]  lat_addr;
  logic [2:0]     lat_len;
  logic [31:0]    lat_wdata;
  logic [2:0]     cnt;

  logic [NCH-1:0] eligible;
  logic [NCH-1:0] sel_oh;
  logic [IW-1:0]  sel_idx;
  logic           sel_any;
  logic           take;
  logic           sel_we;
  logic [AW-1:0]  sel_addr;
  logic [31:0]    sel_wdata;
  logic [2:0]     sel_len;
  logic           abort;
  logic           last_rd;
  logic           last_wr;
  logic [4:0]     rd_base;
  logic [4:0]     wr_base;
  logic [AW-1:0]  next_addr;

  rr_arbiter #(
    .NCH    (NCH),
    .ARB_RR (ARB_RR),
    .IW     (IW)
  ) u_arb (
    .clk     (clk),
    .rst     (rst),
    .en      (take),
    .req     (eligible),
    .gnt     (sel_oh),
    .gnt_idx (sel_idx),
    .gnt_any (sel_any)
  );

  // Request qualification, winner field select and transfer progress decode.
  always_comb begin
    // The channel completing this cycle is masked so a held request is not
    // re-granted; a flush also hides flushable channels for that cycle.
    eligible  = req_valid & ~done & (flush ? ~FLUSH_MASK : '1);
    take      = rdy && (state == ST_IDLE) && sel_any;
    sel_we    = req_we[sel_idx];
    sel_addr  = req_addr[sel_idx*AW +: AW];
    sel_wdata = req_wdata[sel_idx*32 +: 32];
    sel_len   = clamp_len(req_len[sel_idx*3 +: 3]);
    abort     = (state == ST_RD) && flush && (|(FLUSH_MASK & gnt_oh));
    last_rd   = (state == ST_RD) && (cnt == lat_len + 3'd1);
    last_wr   = (state == ST_WR) && (cnt == lat_len);
    // Read bytes land two edges after their address; cnt 2..5 maps to byte 0..3.
    rd_base   = {cnt[1:0] - 2'd2, 3'b000};
    wr_base   = {cnt[1:0], 3'b000};
    next_addr = lat_addr + AW'(cnt);
  end

  // Next-state selection.
  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE: if (take) state_n = sel_we ? ST_WR : ST_RD;
      ST_RD:   if (abort || last_rd) state_n = ST_IDLE;
      ST_WR:   if (last_wr) state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
  end

  // State register; rdy low freezes it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else if (rdy) begin
      state <= state_n;
    end
  end

  // Transfer datapath: latch request, drive RAM per byte, assemble read word.
  always_ff @(posedge clk) begin
    if (rst) begin
      gnt_oh    <= '0;
      lat_addr  <= '0;
      lat_len   <= '0;
      lat_wdata <= '0;
      cnt       <= '0;
      done      <= '0;
      rd_data   <= '0;
      busy      <= 1'b0;
      mem_a     <= '0;
      mem_wr    <= 1'b0;
      mem_dout  <= '0;
    end else if (rdy) begin
      done <= '0;
      case (state)
        ST_IDLE: begin
          if (sel_any) begin
            gnt_oh    <= sel_oh;
            lat_addr  <= sel_addr;
            lat_len   <= sel_len;
            lat_wdata <= sel_wdata;
            cnt       <= 3'd1;
            busy      <= 1'b1;
            mem_a     <= sel_addr;
            rd_data   <= '0;
            if (sel_we) begin
              mem_wr   <= 1'b1;
              mem_dout <= sel_wdata[7:0];
            end
          end
        end
        ST_RD: begin
          if (abort) begin
            cnt     <= '0;
            busy    <= 1'b0;
            mem_a   <= '0;
            rd_data <= '0;
          end else begin
            cnt <= cnt + 3'd1;
            if (cnt < lat_len) mem_a <= next_addr;
            if (cnt >= 3'd2) rd_data[rd_base +: BYTE_W] <= mem_din;
            if (last_rd) begin
              cnt   <= '0;
              done  <= gnt_oh;
              busy  <= 1'b0;
              mem_a <= '0;
            end
          end
        end
        ST_WR: begin
          if (last_wr) begin
            cnt    <= '0;
            done   <= gnt_oh;
            busy   <= 1'b0;
            mem_a  <= '0;
            mem_wr <= 1'b0;
          end else begin
            cnt      <= cnt + 3'd1;
            mem_a    <= next_addr;
            mem_dout <= lat_wdata[wr_base +: BYTE_W];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Scoreboard bench for ram_port_arbiter: directed transfers push expected
// completions, a negedge monitor pops and compares on every done pulse.
module tb_ram_port_arbiter;

  localparam int NCH = 2;
  localparam int AW  = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst = 1'b1;
  logic              rdy = 1'b1;
  logic [NCH-1:0]    req_valid = '0;
  logic [NCH-1:0]    req_we = '0;
  logic [NCH*AW-1:0] req_addr = '0;
  logic [NCH*32-1:0] req_wdata = '0;
  logic [NCH*3-1:0]  req_len = '0;
  logic              flush = 1'b0;
  logic [NCH-1:0]    done;
  logic [31:0]       rd_data;
  logic              busy;
  logic [AW-1:0]     mem_a;
  logic              mem_wr;
  logic [7:0]        mem_dout;
  logic [7:0]        mem_din = '0;

  // Second instance in round-robin mode, write-only traffic.
  logic [NCH-1:0]    req_valid_r = '0;
  logic [NCH-1:0]    req_we_r = '1;
  logic [NCH*AW-1:0] req_addr_r = {32'h0000_0300, 32'h0000_0200};
  logic [NCH*32-1:0] req_wdata_r = {32'h0000_00B1, 32'h0000_00A0};
  logic [NCH*3-1:0]  req_len_r = {3'd1, 3'd1};
  logic              flush_r = 1'b0;
  logic [NCH-1:0]    done_r;
  logic [31:0]       rd_data_r;
  logic              busy_r;
  logic [AW-1:0]     mem_a_r;
  logic              mem_wr_r;
  logic [7:0]        mem_dout_r;
  logic [7:0]        mem_din_r;
  assign mem_din_r = 8'h00;

  ram_port_arbiter #(
    .NCH(NCH), .AW(AW), .ARB_RR(0), .FLUSH_MASK(2'b10)
  ) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .req_valid(req_valid), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_len(req_len), .flush(flush),
    .done(done), .rd_data(rd_data), .busy(busy), .mem_a(mem_a), .mem_wr(mem_wr),
    .mem_dout(mem_dout), .mem_din(mem_din)
  );

  ram_port_arbiter #(
    .NCH(NCH), .AW(AW), .ARB_RR(1), .FLUSH_MASK(2'b10)
  ) dut_rr (
    .clk(clk), .rst(rst), .rdy(rdy), .req_valid(req_valid_r), .req_we(req_we_r),
    .req_addr(req_addr_r), .req_wdata(req_wdata_r), .req_len(req_len_r), .flush(flush_r),
    .done(done_r), .rd_data(rd_data_r), .busy(busy_r), .mem_a(mem_a_r), .mem_wr(mem_wr_r),
    .mem_dout(mem_dout_r), .mem_din(mem_din_r)
  );

  typedef struct { int ch; logic [31:0] data; bit chk; } sb_t;
  typedef struct { int ch; int cyc; } dl_t;

  sb_t         sb[$];
  dl_t         dlog[$];
  logic [39:0] wlog[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc     = 0;

  task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", nm, got, exp);
    end
  endtask

  // Byte RAM with one-cycle registered read, frozen with the rest of the system by rdy.
  logic [7:0] mem [0:8191];
  initial begin
    for (int i = 0; i < 8192; i++) mem[i] = 8'h00;
    mem[13'h1000] = 8'h11;
    mem[13'h1001] = 8'h22;
    mem[13'h1002] = 8'h33;
    mem[13'h1003] = 8'h44;
    mem[13'h1FFF] = 8'hAA;
    mem[13'h0000] = 8'h55;
    forever begin
      @(posedge clk);
      if (rdy) begin
        mem_din <= mem[mem_a[12:0]];
        if (mem_wr) begin
          mem[mem_a[12:0]] = mem_dout;
          wlog.push_back({mem_a, mem_dout});
        end
      end
    end
  end

  // Monitor: every done pulse must match an outstanding expectation for that channel.
  initial begin
    int idx;
    forever begin
      @(negedge clk);
      cyc++;
      for (int c = 0; c < NCH; c++) begin
        if (done[c]) begin
          idx = -1;
          for (int k = 0; k < sb.size(); k++)
            if (idx < 0 && sb[k].ch == c) idx = k;
          if (idx < 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_done: done[%0d]=1 with nothing outstanding, required 0", c);
          end else begin
            check("done_onehot", 64'(done), 64'(1) << c);
            if (sb[idx].chk) check("rd_data", 64'(rd_data), 64'(sb[idx].data));
            dlog.push_back('{c, cyc});
            sb.delete(idx);
          end
        end
      end
    end
  end

  // One transfer on channel ch: push expectation, hold request until done, check latency.
  task automatic xfer(input int ch, input bit we, input logic [31:0] addr,
                      input logic [31:0] wd, input logic [2:0] len,
                      input logic [31:0] exp, input int exp_lat, input string nm);
    int n;
    sb.push_back('{ch, exp, !we});
    req_we[ch]             = we;
    req_addr[ch*32 +: 32]  = addr;
    req_wdata[ch*32 +: 32] = wd;
    req_len[ch*3 +: 3]     = len;
    req_valid[ch]          = 1'b1;
    n = 0;
    while (!done[ch] && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      check({nm, "_timeout"}, 64'(0), 64'(1));
    end else if (exp_lat >= 0) begin
      check({nm, "_latency"}, 64'(n - 1), 64'(exp_lat));
    end
    req_valid[ch] = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: still running at %0t, required finished", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int wbase;
    int rr_seq[$];
    dl_t d0, d1;

    repeat (3) @(negedge clk);
    check("rst_done", 64'(done), 64'(0));
    check("rst_rd_data", 64'(rd_data), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_mem_a", 64'(mem_a), 64'(0));
    check("rst_mem_wr", 64'(mem_wr), 64'(0));
    check("rst_mem_dout", 64'(mem_dout), 64'(0));
    rst = 1'b0;
    @(negedge clk);

    // 4-byte read on ch1 with address stepping.
    fork
      xfer(1, 1'b0, 32'h1000, 32'h0, 3'd4, 32'h4433_2211, 5, "rd4");
      begin
        for (int i = 0; i < 4; i++) begin
          @(negedge clk);
          check("rd4_mem_a", 64'(mem_a), 64'(32'h1000 + i));
        end
      end
    join
    check("rd4_busy_after", 64'(busy), 64'(0));
    @(negedge clk);

    // 2-byte write on ch0, then read it back on ch1.
    wbase = wlog.size();
    xfer(0, 1'b1, 32'h20, 32'h0000_BEEF, 3'd2, 32'h0, 2, "wr2");
    check("wr2_count", 64'(wlog.size() - wbase), 64'(2));
    if (wlog.size() >= wbase + 2) begin
      check("wr2_byte0", 64'(wlog[wbase]), 64'({32'h20, 8'hEF}));
      check("wr2_byte1", 64'(wlog[wbase+1]), 64'({32'h21, 8'hBE}));
    end
    check("wr2_mem_wr_after", 64'(mem_wr), 64'(0));
    xfer(1, 1'b0, 32'h20, 32'h0, 3'd2, 32'h0000_BEEF, 3, "rdback");
    @(negedge clk);

    // Simultaneous requests, fixed priority: ch0 first, ch1 granted at end of done[0] cycle.
    fork
      xfer(0, 1'b0, 32'h1000, 32'h0, 3'd2, 32'h0000_2211, 3, "pri0");
      xfer(1, 1'b0, 32'h1002, 32'h0, 3'd2, 32'h0000_4433, -1, "pri1");
    join
    @(negedge clk);
    if (dlog.size() >= 2) begin
      d0 = dlog[dlog.size()-2];
      d1 = dlog[dlog.size()-1];
      check("pri_first_ch", 64'(d0.ch), 64'(0));
      check("pri_second_ch", 64'(d1.ch), 64'(1));
      check("pri_gap", 64'(d1.cyc - d0.cyc), 64'(4));
    end else begin
      check("pri_dlog_size", 64'(dlog.size()), 64'(2));
    end

    // Flush one cycle after a ch1 read grant: no done, port released.
    req_we[1] = 1'b0;
    req_addr[32 +: 32] = 32'h1000;
    req_len[3 +: 3] = 3'd4;
    req_valid[1] = 1'b1;
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    check("flush_mem_a", 64'(mem_a), 64'(0));
    check("flush_busy", 64'(busy), 64'(0));
    check("flush_rd_data", 64'(rd_data), 64'(0));
    flush = 1'b0;
    req_valid[1] = 1'b0;
    repeat (8) @(negedge clk);
    xfer(0, 1'b0, 32'h1001, 32'h0, 3'd3, 32'h0044_3322, 4, "post_flush");
    @(negedge clk);

    // Two-cycle rdy stall inside a 4-byte read.
    fork
      xfer(1, 1'b0, 32'h1000, 32'h0, 3'd4, 32'h4433_2211, 7, "stall");
      begin
        repeat (2) @(negedge clk);
        rdy = 1'b0;
        @(negedge clk);
        check("stall_mem_a_0", 64'(mem_a), 64'(32'h1001));
        check("stall_busy_0", 64'(busy), 64'(1));
        @(negedge clk);
        check("stall_mem_a_1", 64'(mem_a), 64'(32'h1001));
        rdy = 1'b1;
      end
    join
    @(negedge clk);

    // Reset during a 4-byte write after byte 1 is on the port.
    wbase = wlog.size();
    req_we[0] = 1'b1;
    req_addr[0 +: 32] = 32'h40;
    req_wdata[0 +: 32] = 32'h0102_0304;
    req_len[0 +: 3] = 3'd4;
    req_valid[0] = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("wr_rst_byte1_addr", 64'(mem_a), 64'(32'h41));
    rst = 1'b1;
    @(negedge clk);
    check("wr_rst_mem_wr", 64'(mem_wr), 64'(0));
    check("wr_rst_done", 64'(done), 64'(0));
    check("wr_rst_busy", 64'(busy), 64'(0));
    check("wr_rst_mem_a", 64'(mem_a), 64'(0));
    req_valid[0] = 1'b0;
    rst = 1'b0;
    check("wr_rst_bytes", 64'(wlog.size() - wbase), 64'(2));
    @(negedge clk);

    // Length boundaries and address wrap.
    xfer(0, 1'b0, 32'h1001, 32'h0, 3'd0, 32'h0000_0022, 2, "len0");
    xfer(1, 1'b0, 32'h1000, 32'h0, 3'd7, 32'h4433_2211, 5, "len7");
    xfer(0, 1'b0, 32'hFFFF_FFFF, 32'h0, 3'd2, 32'h0000_55AA, 3, "wrap");
    @(negedge clk);

    // Round-robin instance: both channels held, grants alternate.
    req_valid_r = 2'b01;
    @(negedge clk);
    req_valid_r = 2'b11;
    for (int t = 0; t < 40 && rr_seq.size() < 4; t++) begin
      @(negedge clk);
      if (done_r[0]) rr_seq.push_back(0);
      if (done_r[1]) rr_seq.push_back(1);
    end
    req_valid_r = 2'b00;
    check("rr_count", 64'(rr_seq.size()), 64'(4));
    for (int i = 0; i < rr_seq.size(); i++)
      check("rr_order", 64'(rr_seq[i]), 64'(i % 2));
    repeat (3) @(negedge clk);
    check("rr_idle_busy", 64'(busy_r), 64'(0));
    check("rr_idle_mem_wr", 64'(mem_wr_r), 64'(0));

    check("sb_drained", 64'(sb.size()), 64'(0));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
